// File: rtl/twos_complement_serial_unit.sv
// Serial two's-complement unit: pass / negate / abs of a WIDTH-bit operand, CHUNK bits per cycle.
// Optional build macro TWOS_COMP_SAT_EN saturates the most-negative overflow case to max positive.
module twos_complement_serial_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow,
    output logic             busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = ~MOST_NEG;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] x_next;
    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] r_chunk;
    logic [CHUNK:0]   sum;
    logic [CW-1:0]    idx;
    logic             neg;
    logic             carry;
    logic             is_min;
    logic             in_neg;
    logic             last;

    always_comb begin
        x_chunk = x_sh[CHUNK-1:0];
        sum     = {1'b0, ~x_chunk} + {{CHUNK{1'b0}}, carry};
        r_chunk = neg ? sum[CHUNK-1:0] : x_chunk;
        x_next  = x_sh >> CHUNK;
        in_neg  = mode[0] | (mode[1] & in_data[WIDTH-1]);
        last    = (idx == CW'(N - 1));
    end

    // Result chunks enter at the top so the LSB chunk lands at bit 0 after N shifts.
    if (CHUNK == WIDTH) begin : g_full
        assign acc_next = r_chunk;
    end else begin : g_part
        assign acc_next = {r_chunk, acc[WIDTH-1:CHUNK]};
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_sh      <= '0;
            acc       <= '0;
            idx       <= '0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            is_min    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_sh   <= in_data;
                        neg    <= in_neg;
                        carry  <= in_neg;
                        is_min <= (in_data == MOST_NEG);
                        idx    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    x_sh  <= x_next;
                    acc   <= acc_next;
                    carry <= sum[CHUNK] & neg;
                    idx   <= idx + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        overflow  <= neg & is_min;
`ifdef TWOS_COMP_SAT_EN
                        out_data  <= (neg && is_min) ? MAX_POS : acc_next;
`else
                        out_data  <= acc_next;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_twos_complement_serial_unit.sv
// Directed bench for twos_complement_serial_unit: vector table, backpressure, reset mid-run, CHUNK sweep.
module tb_twos_complement_serial_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        overflow;
    logic        busy;

    logic        s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_mode;
    logic [3:0]  sv_valid, sv_iready, sv_ovf, sv_busy;
    logic [3:0][15:0] sv_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    twos_complement_serial_unit #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overflow(overflow), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int CH = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        twos_complement_serial_unit #(.WIDTH(16), .CHUNK(CH)) u (
            .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(sv_iready[g]),
            .in_data(s_data), .mode(s_mode), .out_valid(sv_valid[g]), .out_ready(1'b1),
            .out_data(sv_data[g]), .overflow(sv_ovf[g]), .busy(sv_busy[g])
        );
    end

    typedef struct {
        logic [15:0] data;
        logic [1:0]  md;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] x, input logic [1:0] md);
        logic        n;
        logic [15:0] r;
        logic        o;
        n = md[0] | (md[1] & x[15]);
        r = n ? (~x + 16'd1) : x;
        o = n && (x == 16'h8000);
`ifdef TWOS_COMP_SAT_EN
        if (o) r = 16'h7FFF;
`endif
        return {o, r};
    endfunction

    // Launch one op on the 16/4 DUT; returns cycles from acceptance edge to out_valid (99 = timeout).
    task automatic run_op(input logic [15:0] d, input logic [1:0] md, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; mode = md;
        @(posedge clk);
        #1 in_valid = 1'b0; in_data = 16'hDEAD;
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = c; break; end
        end
    endtask

    initial begin
        vec_t vt[10];
        int   lat;
        logic [15:0] ovf_data;
        logic [16:0] m;
        int   seen_lat[4];
        logic [15:0] seen_data[4];
        logic seen_ovf[4];
`ifdef TWOS_COMP_SAT_EN
        ovf_data = 16'h7FFF;
`else
        ovf_data = 16'h8000;
`endif
        vt[0] = '{16'h0001, 2'b01, 16'hFFFF, 1'b0};
        vt[1] = '{16'hFF85, 2'b10, 16'h007B, 1'b0};
        vt[2] = '{16'h007B, 2'b10, 16'h007B, 1'b0};
        vt[3] = '{16'h1234, 2'b00, 16'h1234, 1'b0};
        vt[4] = '{16'h0000, 2'b01, 16'h0000, 1'b0};
        vt[5] = '{16'h0005, 2'b11, 16'hFFFB, 1'b0};
        vt[6] = '{16'h8000, 2'b01, ovf_data, 1'b1};
        vt[7] = '{16'h8000, 2'b10, ovf_data, 1'b1};
        vt[8] = '{16'h8000, 2'b00, 16'h8000, 1'b0};
        vt[9] = '{16'h0F00, 2'b11, 16'hF100, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; out_ready = 1'b1;
        s_valid = 1'b0; s_data = '0; s_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset overflow", overflow, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].data, vt[i].md, lat);
            chk($sformatf("vec%0d latency", i), lat, 4);
            chk($sformatf("vec%0d data", i), out_data, vt[i].exp_data);
            chk($sformatf("vec%0d ovf", i), overflow, vt[i].exp_ovf);
            @(posedge clk); #1;
            chk($sformatf("vec%0d one-cycle valid", i), out_valid, 0);
            chk($sformatf("vec%0d in_ready back", i), in_ready, 1);
        end

        // Backpressure: result must hold while new requests are ignored.
        out_ready = 1'b0;
        run_op(16'h00F0, 2'b01, lat);
        chk("bp latency", lat, 4);
        in_valid = 1'b1; in_data = 16'h0001; mode = 2'b01;
        for (int c = 0; c < 5; c++) begin
            chk("bp out_valid", out_valid, 1);
            chk("bp out_data", out_data, 16'hFF10);
            chk("bp in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release valid", out_valid, 0);
        chk("bp release idle", in_ready, 1);
        chk("bp hold data", out_data, 16'hFF10);

        // Reset in the second RUN cycle: no partial result, clean restart.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h1111; mode = 2'b01;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst busy", busy, 0);
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        chk("rst no stray result", lat, 0);
        run_op(16'h0002, 2'b01, lat);
        chk("post-rst latency", lat, 4);
        chk("post-rst data", out_data, 16'hFFFE);
        @(posedge clk); #1;

        // CHUNK sweep against the reference model.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = (k == 0) ? 16'h8000 : (k == 1) ? 16'h0000 : 16'($urandom);
            s_mode  = 2'(k);
            for (int g = 0; g < 4; g++) seen_lat[g] = 99;
            @(posedge clk); #1 s_valid = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 4; g++)
                    if (sv_valid[g] && seen_lat[g] == 99) begin
                        seen_lat[g] = c; seen_data[g] = sv_data[g]; seen_ovf[g] = sv_ovf[g];
                    end
            end
            m = model(s_data, s_mode);
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("sweep%0d u%0d latency", k, g), seen_lat[g],
                    (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 2 : 1);
                chk($sformatf("sweep%0d u%0d data", k, g), seen_data[g], m[15:0]);
                chk($sformatf("sweep%0d u%0d ovf", k, g), seen_ovf[g], m[16]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/twos_complement_serial_unit.md
# twos_complement_serial_unit

Multi-cycle, parametrised two's-complement unit for the multiplier datapath. It negates, takes the absolute value of, or passes through a WIDTH-bit operand, processing CHUNK bits per cycle with a ripple carry held between cycles. It sits between operand registers and the sequential/Booth multiplier cores, which need sign-magnitude conversion of wide operands without a full-width adder. It uses valid/ready handshakes on both sides and flags overflow on the most-negative input.

## Interface
- WIDTH, 16, operand/result width in bits; must be at least 2.
- CHUNK, 4, bits processed per cycle; must divide WIDTH, 1 ≤ CHUNK ≤ WIDTH; N = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand and mode present.
- in_ready  output  1  unit can accept an operand.
- in_data  input  WIDTH  operand, two's complement.
- mode  input  2  00 pass, 01 negate, 10 absolute value, 11 negate. Sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- overflow  output  1  result not representable; valid with out_valid.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset and power-up state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data and the effective negate flag, then go to RUN with chunk index 0.
  - Negate flag: mode 01/11 → 1; mode 10 → in_data[WIDTH-1]; mode 00 → 0.
  - Carry register is set to the negate flag.
- RUN:
  - Cycle i (i = 0..N-1) processes chunk bits [i*CHUNK +: CHUNK].
  - When negating, {carry, r_chunk} = ~x_chunk + carry. When not negating, r_chunk = x_chunk.
  - Results accumulate into an internal shift register.
  - After chunk N-1, go to DONE. out_data, out_valid and overflow update on this transition.
- DONE:
  - out_valid=1.
  - out_data and overflow are held stable until out_ready=1, then go to IDLE.
  - in_ready=0 in RUN and DONE; operations never overlap.
- Arithmetic:
  - The result equals (negate ? −x : x) mod 2^WIDTH.
  - overflow=1 iff negating and x = 1 followed by WIDTH-1 zeros (the most-negative value). Otherwise 0.
  - Negating 0 gives 0 with overflow=0; the final carry-out is discarded.
- out_data holds the last result after the handshake until the next DONE.
- Reset mid-operation (any state):
  - Next state is IDLE.
  - out_valid=0, overflow=0, out_data=0, busy=0, in_ready=1.
  - No partial result is ever presented.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, overflow=0, busy=0.
- Acceptance edge E0 is a rising edge with IDLE, in_valid=1 and rst_n=1.
- out_valid rises after edge E0+N: 4 cycles for 16/4, 1 cycle for CHUNK=WIDTH.
- Consumer handshake edge: out_valid=1 and out_ready=1. out_valid falls and in_ready rises after it.
- Minimum initiation interval is N+2 cycles, with out_ready tied high.
- in_valid and mode are ignored outside IDLE.
- in_data is not required to be held after E0.
- out_ready is ignored outside DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs, except in_ready and busy, which decode state only.

## Configuration
- TWOS_COMP_SAT_EN defined:
  - On overflow, out_data = 0 followed by WIDTH-1 ones (maximum positive value).
  - overflow is still 1.
- TWOS_COMP_SAT_EN undefined:
  - On overflow, out_data is the wrapped result (1 followed by WIDTH-1 zeros), with overflow=1.
- Non-overflow results are identical in both builds.

## Test plan
All tests use WIDTH=16, CHUNK=4.
- Negate 0x0001, out_ready=1 → out_data=0xFFFF, overflow=0, out_valid exactly 4 cycles after acceptance and high for 1 cycle.
- Abs of 0xFF85 → 0x007B. Abs of 0x007B → 0x007B. Pass 0x1234 → 0x1234. Negate 0x0000 → 0x0000. overflow=0 for all.
- Negate 0x8000:
  - without TWOS_COMP_SAT_EN → out_data=0x8000, overflow=1;
  - with it → 0x7FFF, overflow=1.
  - Abs 0x8000 behaves identically.
- Backpressure: negate 0x00F0, out_ready=0 for 5 cycles → out_valid=1 and out_data=0xFF10 stable throughout. in_ready=0 and a new in_valid is ignored. After out_ready=1, return to IDLE next cycle.
- Reset mid-RUN: rst_n=0 at the 2nd RUN cycle of negate 0x1111 → next cycle in_ready=1, out_valid=0, out_data=0, busy=0. No result ever appears. The next operation, negate 0x0002, gives 0xFFFE.
- Parameter sweep: CHUNK=1, 2, 8, 16 over random operands and all modes → results match the reference model and latency equals WIDTH/CHUNK cycles.
